// File: rtl/fifo_gen_pkg.sv
`default_nettype none
// ============================================================================
// fifo_gen_pkg : shared types and constants for the FIFO write-side generator
// Revision     : 1.0
// ============================================================================
package fifo_gen_pkg;

   localparam logic [1:0]  MODE_INC  = 2'd0;
   localparam logic [1:0]  MODE_LFSR = 2'd1;
   localparam logic [1:0]  MODE_TBL  = 2'd2;
   localparam logic [1:0]  MODE_WALK = 2'd3;

   localparam logic [31:0] LFSR_TAPS = 32'h80200003;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } gen_state_e;

   // One step of the right-shifting Galois LFSR.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_gen_lfsr.sv
`default_nettype none
// ============================================================================
// fifo_gen_lfsr : 32-bit Galois LFSR, reloadable with SEED, exposes next state
// Revision      : 1.0
// ============================================================================
module fifo_gen_lfsr
   import fifo_gen_pkg::*;
#(
   parameter int          W    = 8,
   parameter logic [31:0] SEED = 32'h1
) (
   input  logic         w_clk,
   input  logic         w_rst_n,
   input  logic         load_i,
   input  logic         advance_i,
   output logic [W-1:0] next_o
);

   logic [31:0] state_q;
   logic [31:0] state_d;

   assign state_d = lfsr_step(state_q);
   assign next_o  = state_d[W-1:0];

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q <= SEED;
      end else if (load_i) begin
         state_q <= SEED;
      end else if (advance_i) begin
         state_q <= state_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_stream_gen.sv
`default_nettype none
// ============================================================================
// fifo_stream_gen : programmable write-side traffic source for the dual-clock
//                   FIFO (patterns, length, gap, abort, stall/sent statistics)
// Revision        : 1.0
// ============================================================================
module fifo_stream_gen
   import fifo_gen_pkg::*;
#(
   parameter int          DATA_SIZE = 8,
   parameter int          LEN_W     = 16,
   parameter int          GAP_W     = 4,
   parameter int          TBL_DEPTH = 8,
   parameter int          CNT_W     = 16,
   parameter logic [31:0] SEED      = 32'h1,
   localparam int         TBL_AW    = $clog2(TBL_DEPTH)
) (
   input  logic                 w_clk,
   input  logic                 w_rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [1:0]           mode,
   input  logic [LEN_W-1:0]     len,
   input  logic [GAP_W-1:0]     gap,
   input  logic                 tbl_we,
   input  logic [TBL_AW-1:0]    tbl_addr,
   input  logic [DATA_SIZE-1:0] tbl_wdata,
   input  logic                 full,
   output logic                 w_en,
   output logic [DATA_SIZE-1:0] w_data,
   output logic                 busy,
   output logic                 done,
   output logic [LEN_W-1:0]     sent_cnt,
   output logic [CNT_W-1:0]     stall_cnt
);

   logic [DATA_SIZE-1:0] tbl_q [TBL_DEPTH];

   gen_state_e           state_q;
   logic [1:0]           mode_q;
   logic [LEN_W-1:0]     len_q;
   logic [GAP_W-1:0]     gap_q;
   logic [GAP_W-1:0]     gap_cnt_q;
   logic [LEN_W-1:0]     sent_q;
   logic [CNT_W-1:0]     stall_q;
   logic                 w_en_q;
   logic                 busy_q;
   logic                 done_q;
   logic [DATA_SIZE-1:0] data_q;

   logic                 start_ok;
   logic                 accept;
   logic [DATA_SIZE-1:0] lfsr_next;
   logic [1:0]           pat_mode;
   logic [LEN_W-1:0]     pat_idx;
   logic [DATA_SIZE-1:0] pat_lfsr;
   logic [DATA_SIZE-1:0] pat_d;

   assign start_ok = (state_q == ST_IDLE) && start && !abort;
   assign accept   = w_en_q && !full;

   fifo_gen_lfsr #(
      .W    (DATA_SIZE),
      .SEED (SEED)
   ) u_lfsr (
      .w_clk     (w_clk),
      .w_rst_n   (w_rst_n),
      .load_i    (start_ok),
      .advance_i (accept),
      .next_o    (lfsr_next)
   );

   // Pattern for the word presented after this edge: word 0 on start, else i+1.
   always_comb begin
      pat_mode = start_ok ? mode : mode_q;
      pat_idx  = start_ok ? '0 : sent_q + LEN_W'(1);
      pat_lfsr = start_ok ? SEED[DATA_SIZE-1:0] : lfsr_next;
      pat_d    = '0;
      case (pat_mode)
         MODE_INC:  pat_d = DATA_SIZE'(pat_idx);
         MODE_LFSR: pat_d = pat_lfsr;
         MODE_TBL:  pat_d = tbl_q[pat_idx[TBL_AW-1:0]];
         default:   pat_d = DATA_SIZE'(1) << (pat_idx % LEN_W'(DATA_SIZE));
      endcase
   end

   always_ff @(posedge w_clk) begin
      if (tbl_we && !busy_q) begin
         tbl_q[tbl_addr] <= tbl_wdata;
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q   <= ST_IDLE;
         mode_q    <= '0;
         len_q     <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         sent_q    <= '0;
         stall_q   <= '0;
         w_en_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         data_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (w_en_q && full && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
         end
         if (accept) begin
            sent_q <= sent_q + LEN_W'(1);
         end
         case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  mode_q  <= mode;
                  len_q   <= len;
                  gap_q   <= gap;
                  sent_q  <= '0;
                  stall_q <= '0;
                  data_q  <= pat_d;
                  if (len == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_SEND;
                     w_en_q  <= 1'b1;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  w_en_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (accept) begin
                  if (sent_q + LEN_W'(1) == len_q) begin
                     state_q <= ST_DONE;
                     w_en_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     data_q <= pat_d;
                     if (gap_q != '0) begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= gap_q;
                        w_en_q    <= 1'b0;
                     end
                  end
               end
            end
            ST_GAP: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (gap_cnt_q == GAP_W'(1)) begin
                  state_q <= ST_SEND;
                  w_en_q  <= 1'b1;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GAP_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_en      = w_en_q;
   assign w_data    = data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sent_cnt  = sent_q;
   assign stall_cnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_gen.sv
`default_nettype none
// ============================================================================
// tb_fifo_stream_gen : directed table plus randomized runs against a word model
// Revision           : 1.0
// ============================================================================
module tb_fifo_stream_gen;

   logic        w_clk = 1'b0;
   logic        w_rst_n, start, abort, tbl_we, full;
   logic [1:0]  mode;
   logic [15:0] len;
   logic [3:0]  gap;
   logic [2:0]  tbl_addr;
   logic [7:0]  tbl_wdata;
   logic        w_en, busy, done;
   logic [7:0]  w_data;
   logic [15:0] sent_cnt, stall_cnt;

   int          tests = 0;
   int          fails = 0;
   logic [7:0]  tbl_m [8];
   logic [7:0]  got [$];

   always #5 w_clk = ~w_clk;

   fifo_stream_gen dut (
      .w_clk     (w_clk),
      .w_rst_n   (w_rst_n),
      .start     (start),
      .abort     (abort),
      .mode      (mode),
      .len       (len),
      .gap       (gap),
      .tbl_we    (tbl_we),
      .tbl_addr  (tbl_addr),
      .tbl_wdata (tbl_wdata),
      .full      (full),
      .w_en      (w_en),
      .w_data    (w_data),
      .busy      (busy),
      .done      (done),
      .sent_cnt  (sent_cnt),
      .stall_cnt (stall_cnt)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected word i of a run, straight from the pattern definitions.
   function automatic logic [7:0] exp_word(input logic [1:0] m, input int i);
      logic [31:0] s;
      s = 32'h1;
      case (m)
         2'd0: return 8'(i);
         2'd1: begin
            for (int k = 0; k < i; k++) s = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
            return s[7:0];
         end
         2'd2: return tbl_m[i % 8];
         default: return 8'(32'd1 << (i % 8));
      endcase
   endfunction

   task automatic tick();
      @(posedge w_clk);
      #1;
   endtask

   task automatic run(input logic [1:0] m, input int n, input int g,
                      input int st_at, input int st_n, input bit rnd);
      int  idx, stalls, smp, idle, st_left;
      bit  fin, gap_chk, full_now;
      got.delete();
      mode = m; len = 16'(n); gap = 4'(g); start = 1'b1;
      tick();
      start = 1'b0;
      idx = 0; stalls = 0; smp = 0; idle = 0; st_left = st_n; fin = 0; gap_chk = 0;
      check("first_wen", w_en, (n > 0));
      while (!fin) begin
         if (done) begin
            start = 1'b0; full = 1'b0;
            check("done_time", smp, (n > 0) ? n + (n - 1) * g + stalls : 0);
            check("done_words", idx, n);
            check("sent_cnt", sent_cnt, n);
            check("stall_cnt", stall_cnt, stalls);
            check("done_busy", busy, 0);
            fin = 1;
         end else if (smp > n * (g + 1) + stalls + 20) begin
            check("run_timeout", smp, 0);
            fin = 1;
         end else begin
            if (w_en) begin
               check("w_data", w_data, exp_word(m, idx));
               if (gap_chk) begin
                  check("gap_len", idle, g);
                  gap_chk = 0;
               end
            end
            full_now = 0;
            if (w_en) begin
               if (rnd) full_now = ($urandom_range(0, 3) == 0);
               else if (idx == st_at && st_left > 0) begin
                  full_now = 1; st_left--;
               end
            end
            full = full_now;
            if (w_en && full_now) stalls++;
            if (w_en && !full_now) begin
               got.push_back(w_data); idx++; gap_chk = 1; idle = 0;
            end else if (!w_en) begin
               idle++;
            end
            start = rnd && busy && ($urandom_range(0, 7) == 0);
            tick();
            smp++;
         end
      end
      full = 1'b0;
      tick();
      check("done_pulse", done, 0);
   endtask

   typedef struct {
      logic [1:0] m;
      int         n, g, st_at, st_n;
      logic [7:0] w0, w2, wl;
      int         stall;
   } vec_t;

   vec_t vt [7];
   int   cyc;
   bit   seen;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vt[0] = '{2'd0, 5,  0, -1, 0, 8'h00, 8'h02, 8'h04, 0};
      vt[1] = '{2'd1, 3,  0, -1, 0, 8'h01, 8'h02, 8'h02, 0};
      vt[2] = '{2'd1, 3,  0, -1, 0, 8'h01, 8'h02, 8'h02, 0};
      vt[3] = '{2'd2, 10, 2, -1, 0, 8'hA0, 8'hA2, 8'hA1, 0};
      vt[4] = '{2'd0, 4,  0,  1, 3, 8'h00, 8'h02, 8'h03, 3};
      vt[5] = '{2'd3, 10, 1, -1, 0, 8'h01, 8'h04, 8'h02, 0};
      vt[6] = '{2'd0, 0,  0, -1, 0, 8'h00, 8'h00, 8'h00, 0};

      w_rst_n = 1'b0; start = 1'b0; abort = 1'b0; tbl_we = 1'b0; full = 1'b0;
      mode = '0; len = '0; gap = '0; tbl_addr = '0; tbl_wdata = '0;
      repeat (2) @(posedge w_clk);
      #1;
      check("rst_w_en", w_en, 0);
      check("rst_w_data", w_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sent", sent_cnt, 0);
      check("rst_stall", stall_cnt, 0);
      w_rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         tbl_m[i] = 8'hA0 + 8'(i);
         tbl_we = 1'b1; tbl_addr = 3'(i); tbl_wdata = tbl_m[i];
         tick();
      end
      tbl_we = 1'b0;

      for (int v = 0; v < 7; v++) begin
         run(vt[v].m, vt[v].n, vt[v].g, vt[v].st_at, vt[v].st_n, 1'b0);
         check("vec_sent", sent_cnt, vt[v].n);
         check("vec_stall", stall_cnt, vt[v].stall);
         if (vt[v].n >= 3) begin
            check("vec_w0", got[0], vt[v].w0);
            check("vec_w2", got[2], vt[v].w2);
            check("vec_wlast", got[vt[v].n - 1], vt[v].wl);
         end
      end

      // Abort after two words; table writes attempted while busy must not land.
      mode = 2'd0; len = 16'd8; gap = 4'd0; start = 1'b1;
      tick();
      start = 1'b0; cyc = 0;
      while (sent_cnt != 16'd2 && cyc < 20) begin tick(); cyc++; end
      check("abort_reach", sent_cnt, 2);
      abort = 1'b1; full = 1'b1;
      tbl_we = 1'b1; tbl_addr = 3'd0; tbl_wdata = 8'hFF;
      tick();
      abort = 1'b0; full = 1'b0; tbl_we = 1'b0;
      check("abort_w_en", w_en, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sent", sent_cnt, 2);
      seen = 0;
      for (int k = 0; k < 3; k++) begin tick(); seen = seen | done | w_en; end
      check("abort_quiet", seen, 0);
      len = 16'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check("len0_done", done, 1);
      check("len0_w_en", w_en, 0);
      check("len0_sent", sent_cnt, 0);
      tick();
      check("len0_pulse", done, 0);
      run(2'd2, 3, 0, -1, 0, 1'b0);

      // Reset in the middle of a gap.
      mode = 2'd0; len = 16'd5; gap = 4'd3; start = 1'b1;
      tick();
      start = 1'b0; cyc = 0;
      while (!(busy && !w_en) && cyc < 20) begin tick(); cyc++; end
      check("gap_reach", busy && !w_en, 1);
      w_rst_n = 1'b0;
      #1;
      check("mid_w_en", w_en, 0);
      check("mid_w_data", w_data, 0);
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_sent", sent_cnt, 0);
      check("mid_stall", stall_cnt, 0);
      tick();
      w_rst_n = 1'b1;
      run(2'd1, 5, 0, -1, 0, 1'b0);

      for (int r = 0; r < 24; r++) begin
         run(2'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
             int'($urandom_range(0, 3)), -1, 0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
